// File: rtl/stb_port_switch.sv
// stb_port_switch: break-before-make STB/DTB pad switch; drains SPI transfers and floats
// the pads for GUARD cycles before a new config reaches addr/io.
module stb_port_switch #(
    parameter int NCS   = 3,
    parameter int NADDR = 4,
    parameter int NIO   = 4,
    parameter int GUARD = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ctrl_wr,
    input  logic [NCS+2:0]   ctrl_data,
    output logic [NCS+2:0]   ctrl_act,
    output logic             busy,
    input  logic             spi_sclk,
    input  logic             spi_ss,
    input  logic             spi_mosi,
    output logic             spi_miso,
    input  logic [NADDR-1:0] addr_in,
    input  logic             nReset_in,
    input  logic [NIO-1:0]   port_out,
    output logic             i2c_scl,
    inout  wire  [NADDR-1:0] addr,
    inout  wire              nReset,
    inout  wire  [NIO-1:0]   io
);
    localparam int W = NCS + 3;
    typedef enum logic [1:0] {S_ACTIVE, S_DRAIN, S_GUARD, S_APPLY} state_t;
    state_t           state_q;
    logic [W-1:0]     act_q, pend_q, req_d;
    logic             pend_vld_q, req_vld_d;
    logic [7:0]       cnt_q;
    logic             drive, act_stb, act_spi, act_pol;
    logic [NIO-1:0]   io_oe, io_val;
    logic [NADDR-1:0] addr_oe, addr_val;
    logic             scl;
    logic             unused_port_out;
    assign act_stb   = act_q[W-1];
    assign act_spi   = act_q[W-2];
    assign act_pol   = act_q[W-3];
    assign req_d     = ctrl_wr ? ctrl_data : pend_q;
    assign req_vld_d = ctrl_wr | pend_vld_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_GUARD;
            act_q      <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            cnt_q      <= 8'(GUARD - 1);
        end else begin
            // writes while busy only refresh pend; the running sequence is not restarted
            if (ctrl_wr) begin
                pend_q     <= ctrl_data;
                pend_vld_q <= 1'b1;
            end
            case (state_q)
                S_ACTIVE: begin
                    pend_vld_q <= 1'b0;
                    if (req_vld_d && req_d != act_q) begin
                        pend_q     <= req_d;
                        pend_vld_q <= 1'b1;
                        state_q    <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!(act_stb && act_spi && !spi_ss)) begin
                        cnt_q   <= 8'(GUARD - 1);
                        state_q <= S_GUARD;
                    end
                end
                S_GUARD: begin
                    if (cnt_q == 8'd0) state_q <= S_APPLY;
                    else cnt_q <= cnt_q - 8'd1;
                end
                S_APPLY: begin
                    if (pend_vld_q) act_q <= pend_q;
                    pend_vld_q <= ctrl_wr;
                    state_q    <= S_ACTIVE;
                end
            endcase
        end
    end
    assign drive = (state_q == S_ACTIVE) || (state_q == S_DRAIN);
    always_comb begin
        io_oe    = '0;
        io_val   = '0;
        addr_oe  = '0;
        addr_val = '0;
        scl      = 1'b1;
        if (drive && act_stb) begin
            io_oe[0]            = 1'b1;
            io_oe[2]            = 1'b1;
            io_val[0]           = spi_mosi;
            io_val[2]           = act_spi & ~spi_ss;
            addr_oe[NCS-1:0]    = '1;
            addr_val[NCS-1:0]   = act_q[NCS-1:0];
            scl                 = act_spi ? (spi_sclk ^ act_pol) : 1'b1;
        end else if (drive) begin
            io_oe[2:0]  = 3'b111;
            io_val[1:0] = port_out[1:0];
            addr_oe     = ~addr_in;
        end
    end
    for (genvar g = 0; g < NIO; g++) begin : g_io
        assign io[g] = io_oe[g] ? io_val[g] : 1'bz;
    end
    for (genvar g = 0; g < NADDR; g++) begin : g_addr
        assign addr[g] = addr_oe[g] ? addr_val[g] : 1'bz;
    end
    assign nReset          = nReset_in ? 1'bz : 1'b0;
    assign spi_miso        = io[1];
    assign i2c_scl         = scl;
    assign ctrl_act        = act_q;
    assign busy            = state_q != S_ACTIVE;
    assign unused_port_out = ^port_out[NIO-1:2];
endmodule

// File: tb/tb_stb_port_switch.sv
// tb_stb_port_switch: directed bench; two DUT copies on pulled-up and pulled-down pads
// so a floating pad reads 1 on one copy and 0 on the other.
module tb_stb_port_switch;
    logic       clk = 1'b0, reset = 1'b1, ctrl_wr = 1'b0;
    logic [5:0] ctrl_data = '0;
    logic       spi_sclk = 1'b0, spi_ss = 1'b1, spi_mosi = 1'b1, nReset_in = 1'b1;
    logic [3:0] addr_in = 4'b1010, port_out = 4'b0110;
    logic [5:0] act_u, act_d;
    logic       busy_u, busy_d, scl_u, scl_d, miso_u, miso_d;
    wire  [3:0] addr_u, addr_d, io_u, io_d;
    wire        nr_u, nr_d;
    int         total = 0, bad = 0;

    always #5 clk = ~clk;

    stb_port_switch du (.clk(clk), .reset(reset), .ctrl_wr(ctrl_wr), .ctrl_data(ctrl_data),
        .ctrl_act(act_u), .busy(busy_u), .spi_sclk(spi_sclk), .spi_ss(spi_ss), .spi_mosi(spi_mosi),
        .spi_miso(miso_u), .addr_in(addr_in), .nReset_in(nReset_in), .port_out(port_out),
        .i2c_scl(scl_u), .addr(addr_u), .nReset(nr_u), .io(io_u));
    stb_port_switch dd (.clk(clk), .reset(reset), .ctrl_wr(ctrl_wr), .ctrl_data(ctrl_data),
        .ctrl_act(act_d), .busy(busy_d), .spi_sclk(spi_sclk), .spi_ss(spi_ss), .spi_mosi(spi_mosi),
        .spi_miso(miso_d), .addr_in(addr_in), .nReset_in(nReset_in), .port_out(port_out),
        .i2c_scl(scl_d), .addr(addr_d), .nReset(nr_d), .io(io_d));

    for (genvar g = 0; g < 4; g++) begin : g_pull
        pullup   (io_u[g]);
        pulldown (io_d[g]);
        pullup   (addr_u[g]);
        pulldown (addr_d[g]);
    end
    pullup   (nr_u);
    pulldown (nr_d);

    // per pad: 2'b10 = floating, otherwise {0, level}
    function automatic logic [7:0] code(input logic [3:0] u, input logic [3:0] d);
        for (int i = 0; i < 4; i++) code[2*i +: 2] = (u[i] & ~d[i]) ? 2'b10 : {1'b0, d[i]};
    endfunction
    function automatic logic [7:0] ecode(input logic [3:0] oe, input logic [3:0] v);
        for (int i = 0; i < 4; i++) ecode[2*i +: 2] = oe[i] ? {1'b0, v[i]} : 2'b10;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic pads(input string tag, input logic [3:0] io_oe, input logic [3:0] io_v,
                        input logic [3:0] ad_oe, input logic [3:0] ad_v, input logic scl);
        chk({tag, "_io"}, 32'(code(io_u, io_d)), 32'(ecode(io_oe, io_v)));
        chk({tag, "_addr"}, 32'(code(addr_u, addr_d)), 32'(ecode(ad_oe, ad_v)));
        chk({tag, "_scl"}, 32'(scl_u), 32'(scl));
    endtask
    task automatic st(input string tag, input logic b, input logic [5:0] a);
        chk({tag, "_busy"}, 32'(busy_u), 32'(b));
        chk({tag, "_act"}, 32'(act_u), 32'(a));
    endtask
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic wr(input logic [5:0] d);
        ctrl_wr = 1'b1;
        ctrl_data = d;
        step(1);
        ctrl_wr = 1'b0;
    endtask

    initial begin
        step(2);
        st("rst", 1'b1, 6'b0);
        pads("rst", 4'b0, 4'b0, 4'b0, 4'b0, 1'b1);
        chk("rst_nreset", 32'({nr_u, nr_d}), 32'(2'b10));
        reset = 1'b0;
        step(16);
        st("guard_end", 1'b1, 6'b0);
        pads("guard_end", 4'b0, 4'b0, 4'b0, 4'b0, 1'b1);
        step(1);
        st("dtb", 1'b0, 6'b0);
        pads("dtb", 4'b0111, 4'b0010, 4'b0101, 4'b0000, 1'b1);
        chk("dtb_miso", 32'({miso_u, miso_d}), 32'(2'b11));
        wr(6'b110101);
        st("drain1", 1'b1, 6'b0);
        pads("drain1", 4'b0111, 4'b0010, 4'b0101, 4'b0000, 1'b1);
        step(1);
        pads("g1", 4'b0, 4'b0, 4'b0, 4'b0, 1'b1);
        step(15);
        st("g16", 1'b1, 6'b0);
        pads("g16", 4'b0, 4'b0, 4'b0, 4'b0, 1'b1);
        step(1);
        st("apply1", 1'b1, 6'b0);
        pads("apply1", 4'b0, 4'b0, 4'b0, 4'b0, 1'b1);
        step(1);
        st("spi", 1'b0, 6'b110101);
        pads("spi", 4'b0101, 4'b0001, 4'b0111, 4'b0101, 1'b0);
        spi_ss = 1'b0;
        spi_sclk = 1'b1;
        #1;
        pads("spi_xfer", 4'b0101, 4'b0101, 4'b0111, 4'b0101, 1'b1);
        chk("spi_miso_z", 32'({miso_u, miso_d}), 32'(2'b10));
        wr(6'b000000);
        st("hold1", 1'b1, 6'b110101);
        pads("hold1", 4'b0101, 4'b0101, 4'b0111, 4'b0101, 1'b1);
        step(5);
        st("hold6", 1'b1, 6'b110101);
        pads("hold6", 4'b0101, 4'b0101, 4'b0111, 4'b0101, 1'b1);
        spi_ss = 1'b1;
        step(1);
        pads("hold_g1", 4'b0, 4'b0, 4'b0, 4'b0, 1'b1);
        step(15);
        pads("hold_g16", 4'b0, 4'b0, 4'b0, 4'b0, 1'b1);
        step(1);
        st("hold_apply", 1'b1, 6'b110101);
        step(1);
        st("back_dtb", 1'b0, 6'b0);
        pads("back_dtb", 4'b0111, 4'b0010, 4'b0101, 4'b0000, 1'b1);
        wr(6'b100011);
        step(1);
        wr(6'b110001);
        step(14);
        st("two_g", 1'b1, 6'b0);
        pads("two_g", 4'b0, 4'b0, 4'b0, 4'b0, 1'b1);
        step(1);
        st("two_apply", 1'b1, 6'b0);
        step(1);
        st("two_done", 1'b0, 6'b110001);
        pads("two_done", 4'b0101, 4'b0001, 4'b0111, 4'b0001, 1'b1);
        step(3);
        st("two_once", 1'b0, 6'b110001);
        wr(6'b110001);
        st("same", 1'b0, 6'b110001);
        pads("same", 4'b0101, 4'b0001, 4'b0111, 4'b0001, 1'b1);
        step(2);
        st("same2", 1'b0, 6'b110001);
        wr(6'b111001);
        step(17);
        st("pol_apply", 1'b1, 6'b110001);
        step(1);
        st("pol", 1'b0, 6'b111001);
        chk("pol_scl_hi", 32'(scl_u), 32'(1'b0));
        spi_sclk = 1'b0;
        #1;
        chk("pol_scl_lo", 32'(scl_u), 32'(1'b1));
        wr(6'b000000);
        step(2);
        nReset_in = 1'b0;
        #1;
        chk("guard_nreset0", 32'({nr_u, nr_d}), 32'(2'b00));
        pads("guard_nr", 4'b0, 4'b0, 4'b0, 4'b0, 1'b1);
        nReset_in = 1'b1;
        #1;
        chk("guard_nreset1", 32'({nr_u, nr_d}), 32'(2'b10));
        step(3);
        reset = 1'b1;
        #1;
        st("mid_rst", 1'b1, 6'b0);
        pads("mid_rst", 4'b0, 4'b0, 4'b0, 4'b0, 1'b1);
        reset = 1'b0;
        step(16);
        st("post_rst_g", 1'b1, 6'b0);
        step(1);
        st("post_rst", 1'b0, 6'b0);
        pads("post_rst", 4'b0111, 4'b0010, 4'b0101, 4'b0000, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
